// File: rtl/onehot_decode_seq_if.sv
// Handshake and output bundle for onehot_decode_seq: code transfer in,
// timed one-hot strobe and status out.
interface onehot_decode_seq_if;
  logic       code_valid;
  logic [2:0] code_in;
  logic       code_ready;
  logic [7:0] dout;
  logic       busy;
  logic       done;

  modport master (
    output code_valid, code_in,
    input  code_ready, dout, busy, done
  );

  modport slave (
    input  code_valid, code_in,
    output code_ready, dout, busy, done
  );
endinterface

// File: rtl/onehot_decode_seq.sv
// Sequenced 3-to-8 decoder: accepts a code over valid/ready, drives its
// one-hot line for HOLD cycles, then forces one idle gap cycle.
module onehot_decode_seq #(
  parameter int unsigned HOLD = 4,
  parameter int unsigned CW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  onehot_decode_seq_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [7:0]    dout_q,  dout_d;
  logic          done_q,  done_d;
  logic          transfer;

  assign bus.code_ready = (state_q == S_IDLE) && !en;
  assign transfer       = bus.code_valid && bus.code_ready;
  assign bus.dout       = dout_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        dout_d = '0;
        if (transfer) begin
          dout_d  = 8'h01 << bus.code_in;
          cnt_d   = CNT_INIT;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        // Abort outranks the terminal count, so done never fires on abort.
        if (en) begin
          state_d = S_IDLE;
          dout_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = S_GAP;
          dout_d  = '0;
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        dout_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        dout_d  = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_onehot_decode_seq.sv
// Directed bench for onehot_decode_seq: a vector table for single transfers,
// disable and abort, plus hand sequences for sweep, async reset and HOLD=1.
module tb_onehot_decode_seq;

  logic clk;
  logic rst_n;
  logic en;
  logic en1;

  onehot_decode_seq_if bus ();
  onehot_decode_seq_if bus1 ();

  onehot_decode_seq #(.HOLD(4), .CW(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  onehot_decode_seq #(.HOLD(1), .CW(8)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en1),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  typedef struct {
    logic       en;
    logic       valid;
    logic [2:0] code;
    logic [7:0] dout;
    logic       busy;
    logic       done;
    logic       ready;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Let combinational outputs settle, then check the one-hot-or-zero invariant.
  task automatic settle();
    #1;
    chk("onehot0", 8'(($onehot0(bus.dout) && $onehot0(bus1.dout)) ? 1 : 0), 8'd1);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic b,
                         input logic dn, input logic r);
    chk({tag, ".dout"},  bus.dout,             d);
    chk({tag, ".busy"},  8'(bus.busy),         8'(b));
    chk({tag, ".done"},  8'(bus.done),         8'(dn));
    chk({tag, ".ready"}, 8'(bus.code_ready),   8'(r));
  endtask

  task automatic chk_all1(input string tag, input logic [7:0] d, input logic b,
                          input logic dn, input logic r);
    chk({tag, ".dout"},  bus1.dout,            d);
    chk({tag, ".busy"},  8'(bus1.busy),        8'(b));
    chk({tag, ".done"},  8'(bus1.done),        8'(dn));
    chk({tag, ".ready"}, 8'(bus1.code_ready),  8'(r));
  endtask

  initial begin
    int done_cnt;
    tests = 0;
    fails = 0;

    //          en    valid code  dout   busy  done  ready
    tbl[0]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 3'd1, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 3'd1, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 8'h04, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 3'd0, 8'h04, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 3'd0, 8'h04, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 3'd7, 8'h80, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 3'd7, 8'h80, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 3'd3, 8'h08, 1'b1, 1'b0, 1'b0};
    tbl[22] = '{1'b0, 1'b0, 3'd6, 8'h08, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{1'b0, 1'b0, 3'd6, 8'h08, 1'b1, 1'b0, 1'b0};
    tbl[24] = '{1'b1, 1'b0, 3'd6, 8'h08, 1'b1, 1'b0, 1'b0};
    tbl[25] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1};

    rst_n           = 1'b0;
    en              = 1'b0;
    en1             = 1'b0;
    bus.code_valid  = 1'b0;
    bus.code_in     = 3'd0;
    bus1.code_valid = 1'b0;
    bus1.code_in    = 3'd0;

    settle();
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b1);
    chk_all1("reset1", 8'h00, 1'b0, 1'b0, 1'b1);
    #11 rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      en             = tbl[i].en;
      bus.code_valid = tbl[i].valid;
      bus.code_in    = tbl[i].code;
      settle();
      chk_all($sformatf("vec%0d", i), tbl[i].dout, tbl[i].busy, tbl[i].done, tbl[i].ready);
    end

    // Disable gating: held request must be ignored for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      en             = 1'b1;
      bus.code_valid = 1'b1;
      bus.code_in    = 3'd2;
      settle();
      chk($sformatf("dis%0d.ready", i), 8'(bus.code_ready), 8'd0);
      chk($sformatf("dis%0d.dout", i),  bus.dout,           8'h00);
    end
    @(negedge clk);
    en = 1'b0;
    settle();
    chk("dis_end.ready", 8'(bus.code_ready), 8'd1);
    @(negedge clk);
    bus.code_valid = 1'b0;
    settle();
    chk("dis_end.dout", bus.dout, 8'h04);
    repeat (6) @(negedge clk);
    settle();
    chk("dis_drain.busy", 8'(bus.busy), 8'd0);

    // Back-to-back sweep with valid held: period HOLD+2 = 6 samples.
    done_cnt = 0;
    for (int n = 0; n < 48; n++) begin
      int p;
      int k;
      logic [7:0] exp_d;
      p = n % 6;
      k = n / 6;
      exp_d = (p >= 1 && p <= 4) ? (8'h01 << k) : 8'h00;
      @(negedge clk);
      bus.code_valid = 1'b1;
      bus.code_in    = 3'(k);
      settle();
      if (bus.done) done_cnt++;
      chk_all($sformatf("sweep%0d", n), exp_d, (p != 0), (p == 5), (p == 0));
    end
    chk("sweep.done_count", 8'(done_cnt), 8'd8);

    // Async reset in the middle of a DRIVE.
    @(negedge clk);
    bus.code_valid = 1'b1;
    bus.code_in    = 3'd4;
    settle();
    chk("arst.ready", 8'(bus.code_ready), 8'd1);
    @(negedge clk);
    bus.code_valid = 1'b0;
    settle();
    chk("arst.dout_pre", bus.dout, 8'h10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.dout_now", bus.dout, 8'h00);
    chk("arst.busy_now", 8'(bus.busy), 8'd0);
    chk("arst.done_now", 8'(bus.done), 8'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    bus.code_valid = 1'b1;
    bus.code_in    = 3'd1;
    settle();
    chk_all("arst_rel", 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus.code_valid = 1'b0;
    settle();
    chk("arst_rel.dout", bus.dout, 8'h02);
    repeat (6) @(negedge clk);

    // HOLD=1 instance: codes 0 then 4 with valid held.
    @(negedge clk);
    bus1.code_valid = 1'b1;
    bus1.code_in    = 3'd0;
    settle();
    chk_all1("h1_0", 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    settle();
    chk_all1("h1_1", 8'h01, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    settle();
    chk_all1("h1_2", 8'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    bus1.code_in = 3'd4;
    settle();
    chk_all1("h1_3", 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    bus1.code_valid = 1'b0;
    settle();
    chk_all1("h1_4", 8'h10, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    settle();
    chk_all1("h1_5", 8'h00, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    settle();
    chk_all1("h1_6", 8'h00, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
